// File: rtl/matrix_stream_loader.sv
// Streams signed elements over valid/ready into a SIZE_A x SIZE_B shadow buffer,
// then commits the whole matrix to out_matrix in a single edge.
module matrix_stream_loader #(
    parameter int BITS   = 64,
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   col_major,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic signed [BITS-1:0] in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       load_count,
    output logic signed [BITS-1:0] out_matrix [SIZE_A][SIZE_B]
);

    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                 state;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic                   mode;
    logic signed [BITS-1:0] shadow [SIZE_A][SIZE_B];

    logic at_row_last;
    logic at_col_last;

    assign at_row_last = (row == ROW_LAST);
    assign at_col_last = (col == COL_LAST);

    // in_ready and busy are registered alongside state so they always match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            mode       <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_count <= '0;
            for (int i = 0; i < SIZE_A; i++) begin
                for (int j = 0; j < SIZE_B; j++) begin
                    shadow[i][j]     <= '0;
                    out_matrix[i][j] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        row      <= '0;
                        col      <= '0;
                        mode     <= col_major;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    // An aborted cycle drops its beat even though in_ready is high.
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        shadow[row][col] <= in_data;
                        if (at_row_last && at_col_last) begin
                            state    <= COMMIT;
                            in_ready <= 1'b0;
                        end else if (!mode) begin
                            if (at_col_last) begin
                                col <= '0;
                                row <= row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end else begin
                            if (at_row_last) begin
                                row <= '0;
                                col <= col + CW'(1);
                            end else begin
                                row <= row + RW'(1);
                            end
                        end
                    end
                end
                COMMIT: begin
                    out_matrix <= shadow;
                    done       <= 1'b1;
                    load_count <= load_count + CNT_W'(1);
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
